timer_mode_controller: RTL and testbench

Front-panel controller for the timer/stopwatch/clock/alarm datapath. It synchronises and debounces the three buttons, detects short and long presses, and runs the mode FSM plus the per-function sub-FSMs. It drives one-cycle command pulses and level enables to the counting datapath, and owns the ringSound output. It runs on the 100 Hz system clock; all durations below are in clock cycles.

---
 rtl/timer_mode_controller.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_timer_mode_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mode_controller.sv
// Front-panel controller for the timer/stopwatch/clock/alarm datapath.
// Conditions three buttons, decodes press events and drives mode/sub-FSM commands.
module timer_mode_controller #(
    parameter int DEBOUNCE_CYCLES   = 2,
    parameter int LONG_PRESS_CYCLES = 200,
    parameter int LAP_DEPTH         = 5,
    parameter int RING_CYCLES       = 3000
) (
    input  logic                                 i_clockSignal,
    input  logic                                 i_resetSignal,
    input  logic                                 i_modeInput,
    input  logic                                 i_startOrStop,
    input  logic                                 i_splitOrReset,
    input  logic                                 i_countdownZero,
    input  logic                                 i_alarmMatch,
    output logic [1:0]                           o_mode,
    output logic                                 o_timerLoad,
    output logic                                 o_timerRunning,
    output logic                                 o_timerClear,
    output logic                                 o_stopwatchRunning,
    output logic                                 o_lapCapture,
    output logic [$clog2(LAP_DEPTH > 1 ? LAP_DEPTH : 2)-1:0] o_lapIndex,
    output logic                                 o_lapFull,
    output logic                                 o_stopwatchClear,
    output logic                                 o_clockSetEnable,
    output logic                                 o_alarmArmed,
    output logic                                 o_ringSound
);

    localparam int LAP_W  = $clog2(LAP_DEPTH > 1 ? LAP_DEPTH : 2);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES > 1 ? LONG_PRESS_CYCLES : 2);
    localparam int RING_W = $clog2(RING_CYCLES > 1 ? RING_CYCLES : 2);

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_DONE} t_state_t;
    typedef enum logic {SW_STOP, SW_RUN} sw_state_t;

    // Button index: 0 mode, 1 start/stop, 2 split/reset
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_deb;
    logic [2:0]      r_debPrev;
    logic [DB_W-1:0] r_debCnt [3];

    logic [HOLD_W-1:0] r_holdCnt;
    logic              r_longFired;

    t_state_t  r_tState;
    t_state_t  w_tNext;
    sw_state_t r_swState;
    sw_state_t w_swNext;

    logic [1:0]       r_mode;
    logic             r_timerLoad;
    logic             r_timerRunning;
    logic             r_timerClear;
    logic             r_lapCapture;
    logic [LAP_W-1:0] r_lapIndex;
    logic             r_lapFull;
    logic             r_swClear;
    logic             r_clockSet;
    logic             r_alarmArmed;
    logic             r_alarmPrev;
    logic             r_ring;
    logic [RING_W-1:0] r_ringCnt;

    logic w_modeEv;
    logic w_startEv;
    logic w_shortEv;
    logic w_longEv;
    logic w_m;
    logic w_s;
    logic w_sp;
    logic w_lp;
    logic w_btnAny;
    logic w_act;
    logic w_tZero;
    logic w_alarmRise;
    logic w_timerLoad;
    logic w_timerClear;
    logic w_lapCap;
    logic w_swClear;

    // Two-flop synchroniser plus consecutive-sample debouncer per button
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_debPrev <= '0;
            for (int b = 0; b < 3; b++) r_debCnt[b] <= '0;
        end else begin
            r_sync1   <= {i_splitOrReset, i_startOrStop, i_modeInput};
            r_sync2   <= r_sync1;
            r_debPrev <= r_deb;
            for (int b = 0; b < 3; b++) begin
                if (r_sync2[b] != r_deb[b]) begin
                    if (r_debCnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_deb[b]    <= r_sync2[b];
                        r_debCnt[b] <= '0;
                    end else begin
                        r_debCnt[b] <= r_debCnt[b] + DB_W'(1);
                    end
                end else begin
                    r_debCnt[b] <= '0;
                end
            end
        end
    end

    // Split hold timer: one long event per hold, suppresses the release event
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal) begin
            r_holdCnt   <= '0;
            r_longFired <= 1'b0;
        end else if (!r_deb[2]) begin
            r_holdCnt   <= '0;
            r_longFired <= 1'b0;
        end else begin
            if (r_holdCnt != HOLD_W'(LONG_PRESS_CYCLES - 1))
                r_holdCnt <= r_holdCnt + HOLD_W'(1);
            if (w_longEv)
                r_longFired <= 1'b1;
        end
    end

    // Event decode, priority mode > start > split, and ring consumption
    always_comb begin
        w_modeEv    = r_deb[0] & ~r_debPrev[0];
        w_startEv   = r_deb[1] & ~r_debPrev[1];
        w_shortEv   = ~r_deb[2] & r_debPrev[2] & ~r_longFired;
        w_longEv    = r_deb[2] & ~r_longFired &
                      (r_holdCnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
        w_m         = w_modeEv;
        w_s         = w_startEv & ~w_modeEv;
        w_sp        = w_shortEv & ~w_modeEv & ~w_startEv;
        w_lp        = w_longEv & ~w_modeEv & ~w_startEv;
        w_btnAny    = w_modeEv | w_startEv | w_shortEv | w_longEv;
        w_act       = ~r_ring;
        w_tZero     = (r_tState == T_RUN) & i_countdownZero;
        w_alarmRise = i_alarmMatch & ~r_alarmPrev & r_alarmArmed;
    end

    // Timer next-state and command pulses
    always_comb begin
        w_tNext      = r_tState;
        w_timerLoad  = 1'b0;
        w_timerClear = 1'b0;
        if (w_tZero) begin
            w_tNext = T_DONE;
        end else if (w_act && r_mode == 2'd0) begin
            unique case (r_tState)
                T_IDLE: begin
                    if (w_s) begin
                        w_timerLoad = 1'b1;
                        w_tNext     = T_RUN;
                    end else if (w_sp) begin
                        w_timerClear = 1'b1;
                    end
                end
                T_RUN: begin
                    if (w_s) w_tNext = T_PAUSE;
                end
                T_PAUSE: begin
                    if (w_s) begin
                        w_tNext = T_RUN;
                    end else if (w_sp) begin
                        w_timerClear = 1'b1;
                        w_tNext      = T_IDLE;
                    end
                end
                T_DONE: begin
                    if (w_sp) begin
                        w_timerClear = 1'b1;
                        w_tNext      = T_IDLE;
                    end
                end
                default: w_tNext = T_IDLE;
            endcase
        end
    end

    // Stopwatch next-state, lap capture and clear pulses
    always_comb begin
        w_swNext  = r_swState;
        w_lapCap  = 1'b0;
        w_swClear = 1'b0;
        if (w_act && r_mode == 2'd1) begin
            if (w_lp) begin
                w_swNext  = SW_STOP;
                w_swClear = 1'b1;
            end else begin
                unique case (r_swState)
                    SW_STOP: begin
                        if (w_s) w_swNext = SW_RUN;
                        else if (w_sp) w_swClear = 1'b1;
                    end
                    SW_RUN: begin
                        if (w_s) w_swNext = SW_STOP;
                        else if (w_sp && !r_lapFull) w_lapCap = 1'b1;
                    end
                    default: w_swNext = SW_STOP;
                endcase
            end
        end
    end

    // Sub-FSM state registers and registered command pulses
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal) begin
            r_tState       <= T_IDLE;
            r_swState      <= SW_STOP;
            r_timerLoad    <= 1'b0;
            r_timerClear   <= 1'b0;
            r_timerRunning <= 1'b0;
            r_lapCapture   <= 1'b0;
            r_swClear      <= 1'b0;
        end else begin
            r_tState       <= w_tNext;
            r_swState      <= w_swNext;
            r_timerLoad    <= w_timerLoad;
            r_timerClear   <= w_timerClear;
            r_timerRunning <= (r_tState == T_RUN) && (w_tNext == T_RUN);
            r_lapCapture   <= w_lapCap;
            r_swClear      <= w_swClear;
        end
    end

    // Lap slot pointer advances after each capture pulse
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal || w_swClear) begin
            r_lapIndex <= '0;
            r_lapFull  <= 1'b0;
        end else if (r_lapCapture) begin
            if (r_lapIndex == LAP_W'(LAP_DEPTH - 1))
                r_lapFull <= 1'b1;
            else
                r_lapIndex <= r_lapIndex + LAP_W'(1);
        end
    end

    // Mode rotation, clock-set and alarm-arm levels
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal) begin
            r_mode       <= 2'd0;
            r_clockSet   <= 1'b0;
            r_alarmArmed <= 1'b0;
            r_alarmPrev  <= 1'b0;
        end else begin
            r_alarmPrev <= i_alarmMatch;
            if (w_act && w_m)
                r_mode <= r_mode + 2'd1;
            if (w_act && w_m && r_mode == 2'd2)
                r_clockSet <= 1'b0;
            else if (w_act && w_lp && r_mode == 2'd2)
                r_clockSet <= ~r_clockSet;
            if (w_act && r_mode == 2'd3) begin
                if (w_s) r_alarmArmed <= ~r_alarmArmed;
                else if (w_sp) r_alarmArmed <= 1'b0;
            end
        end
    end

    // Buzzer: triggers win over clears and restart the silence timer
    always_ff @(posedge i_clockSignal) begin
        if (i_resetSignal) begin
            r_ring    <= 1'b0;
            r_ringCnt <= '0;
        end else if (w_tZero || w_alarmRise) begin
            r_ring    <= 1'b1;
            r_ringCnt <= '0;
        end else if (r_ring &&
                     (w_btnAny || r_ringCnt == RING_W'(RING_CYCLES - 1))) begin
            r_ring    <= 1'b0;
            r_ringCnt <= '0;
        end else if (r_ring) begin
            r_ringCnt <= r_ringCnt + RING_W'(1);
        end
    end

    assign o_mode             = r_mode;
    assign o_timerLoad        = r_timerLoad;
    assign o_timerRunning     = r_timerRunning;
    assign o_timerClear       = r_timerClear;
    assign o_stopwatchRunning = (r_swState == SW_RUN);
    assign o_lapCapture       = r_lapCapture;
    assign o_lapIndex         = r_lapIndex;
    assign o_lapFull          = r_lapFull;
    assign o_stopwatchClear   = r_swClear;
    assign o_clockSetEnable   = r_clockSet;
    assign o_alarmArmed       = r_alarmArmed;
    assign o_ringSound        = r_ring;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed bench for timer_mode_controller.
// Hand-computed expectations, one check task, summary at the end.
module tb_timer_mode_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_split = 1'b0;
    logic       cd_zero = 1'b0;
    logic       al_match = 1'b0;
    logic [1:0] mode;
    logic       t_load, t_run, t_clr;
    logic       sw_run, lap_cap, lap_full, sw_clr;
    logic [2:0] lap_idx;
    logic       clk_set, armed, ring;

    int n_pass = 0;
    int n_total = 0;
    int cnt_lap = 0;
    int cnt_swclr = 0;
    int cnt_tload = 0;
    logic [2:0] lap_log [16];

    always #5 clk = ~clk;

    timer_mode_controller dut (
        .i_clockSignal     (clk),
        .i_resetSignal     (rst),
        .i_modeInput       (btn_mode),
        .i_startOrStop     (btn_start),
        .i_splitOrReset    (btn_split),
        .i_countdownZero   (cd_zero),
        .i_alarmMatch      (al_match),
        .o_mode            (mode),
        .o_timerLoad       (t_load),
        .o_timerRunning    (t_run),
        .o_timerClear      (t_clr),
        .o_stopwatchRunning(sw_run),
        .o_lapCapture      (lap_cap),
        .o_lapIndex        (lap_idx),
        .o_lapFull         (lap_full),
        .o_stopwatchClear  (sw_clr),
        .o_clockSetEnable  (clk_set),
        .o_alarmArmed      (armed),
        .o_ringSound       (ring)
    );

    wire [14:0] all_outs = {mode, t_load, t_run, t_clr, sw_run, lap_cap,
                            lap_idx, lap_full, sw_clr, clk_set, armed, ring};

    // Pulse counters, sampled just after each active edge
    always @(posedge clk) begin
        #2;
        if (lap_cap) begin
            lap_log[cnt_lap[3:0]] = lap_idx;
            cnt_lap = cnt_lap + 1;
        end
        if (sw_clr) cnt_swclr = cnt_swclr + 1;
        if (t_load) cnt_tload = cnt_tload + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_start = v;
            default: btn_split = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        tick(hold);
        set_btn(b, 1'b0);
        tick(10);
    endtask

    int base;
    int exp_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        tick(3);
        check("reset_outs", 32'(all_outs), 32'd0);
        rst = 1'b0;
        tick(2);

        // Timer start: load 5 cycles after raw edge, running the cycle after
        btn_start = 1'b1;
        tick(4);
        check("tload_early", 32'(t_load), 32'd0);
        tick(1);
        check("tload_pulse", 32'(t_load), 32'd1);
        check("trun_lag", 32'(t_run), 32'd0);
        tick(1);
        check("tload_end", 32'(t_load), 32'd0);
        check("trun_on", 32'(t_run), 32'd1);
        btn_start = 1'b0;
        tick(8);
        check("tload_once", 32'(cnt_tload), 32'd1);

        // Countdown reaches zero: stop and ring, auto-silence after 3000
        cd_zero = 1'b1;
        tick(1);
        cd_zero = 1'b0;
        check("zero_trun", 32'(t_run), 32'd0);
        check("zero_ring", 32'(ring), 32'd1);
        tick(2999);
        check("ring_hold", 32'(ring), 32'd1);
        tick(1);
        check("ring_auto_off", 32'(ring), 32'd0);

        // Mode rotation with wrap
        for (int i = 0; i < 5; i++) begin
            press(0, 6);
            check("mode_seq", 32'(mode), 32'(exp_seq[i]));
        end
        press(1, 6);
        check("sw_start", 32'(sw_run), 32'd1);
        press(0, 6);
        check("sw_keeps_run", 32'(sw_run), 32'd1);
        check("mode_2", 32'(mode), 32'd2);
        press(0, 6);
        press(0, 6);
        press(0, 6);
        check("mode_back_1", 32'(mode), 32'd1);

        // Six splits while running: five laps, then full
        base = cnt_lap;
        for (int i = 0; i < 6; i++) begin
            press(2, 6);
            if (i == 3) check("lap_not_full", 32'(lap_full), 32'd0);
            if (i == 4) check("lap_full5", 32'(lap_full), 32'd1);
        end
        check("lap_count", 32'(cnt_lap - base), 32'd5);
        for (int i = 0; i < 5; i++)
            check("lap_slot", 32'(lap_log[(base + i) % 16]), 32'(i));
        check("lap_idx_hold", 32'(lap_idx), 32'd4);
        press(1, 6);
        check("sw_stop", 32'(sw_run), 32'd0);
        base = cnt_swclr;
        press(2, 6);
        check("swclr_short", 32'(cnt_swclr - base), 32'd1);
        check("lapidx_clr", 32'(lap_idx), 32'd0);
        check("lapfull_clr", 32'(lap_full), 32'd0);

        // Long hold: one clear, nothing on release
        base = cnt_swclr;
        press(2, 250);
        check("swclr_long", 32'(cnt_swclr - base), 32'd1);
        // Medium hold: action only on release
        base = cnt_swclr;
        btn_split = 1'b1;
        tick(50);
        check("swclr_mid_hold", 32'(cnt_swclr - base), 32'd0);
        btn_split = 1'b0;
        tick(10);
        check("swclr_mid_rel", 32'(cnt_swclr - base), 32'd1);

        // Bouncing start settles into exactly one press
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            tick(1);
        end
        btn_start = 1'b1;
        tick(10);
        btn_start = 1'b0;
        tick(10);
        check("bounce_once", 32'(sw_run), 32'd1);

        // Simultaneous mode and start: start dropped
        btn_mode = 1'b1;
        btn_start = 1'b1;
        tick(6);
        btn_mode = 1'b0;
        btn_start = 1'b0;
        tick(10);
        check("simul_mode", 32'(mode), 32'd2);
        check("simul_sw", 32'(sw_run), 32'd1);

        // Clock mode: long press toggles set, leaving mode clears it
        press(2, 250);
        check("clkset_on", 32'(clk_set), 32'd1);
        press(0, 6);
        check("mode_3", 32'(mode), 32'd3);
        check("clkset_leave", 32'(clk_set), 32'd0);

        // Alarm: arm, match rings, button silences without disarming
        press(1, 6);
        check("armed_on", 32'(armed), 32'd1);
        al_match = 1'b1;
        tick(1);
        al_match = 1'b0;
        check("alarm_ring", 32'(ring), 32'd1);
        tick(3);
        press(1, 6);
        check("ring_btn_off", 32'(ring), 32'd0);
        check("armed_kept", 32'(armed), 32'd1);

        // Reset mid-ring
        al_match = 1'b1;
        tick(1);
        al_match = 1'b0;
        check("ring_again", 32'(ring), 32'd1);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("reset_mid", 32'(all_outs), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
